// File: rtl/store_buffer_drain_ctrl.sv
// Store buffer drain controller: decides when to pop the oldest store, latches it and
// presents it to the dcache write port, stalling the pipeline only for mandatory drains.
module store_buffer_drain_ctrl #(
  parameter int unsigned NUM_ENTRIES  = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned HIGH_WM      = 6,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned ENTRY_W      = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   sb_count,
  input  logic               sb_push,
  input  logic               sb_search_active,
  input  logic [ENTRY_W-1:0] sb_oldest_info,
  output logic               sb_get_oldest,
  input  logic               cache_port_busy,
  output logic               wr_valid,
  output logic [ENTRY_W-1:0] wr_info,
  input  logic               wr_ready,
  output logic               stall_pipe,
  input  logic               fence_req,
  output logic               fence_done,
  output logic [15:0]        drained_cnt
);

  localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] HighWm  = CNT_W'(HIGH_WM);
  localparam logic [TMR_W-1:0] TmrMax  = TMR_W'(IDLE_TIMEOUT);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e             r_state, w_state_d;
  logic [TMR_W-1:0]   r_timer, w_timer_d;
  logic               r_fence_pending, w_fence_pending_d;
  logic [ENTRY_W-1:0] r_wr_info;
  logic [15:0]        r_drained_cnt;

  logic w_nonempty, w_mandatory, w_opportunistic, w_accept;

  assign w_nonempty      = (sb_count != '0);
  assign w_mandatory     = (sb_count == FullCnt) ||
                           (r_fence_pending && w_nonempty) ||
                           ((r_timer == TmrMax) && w_nonempty);
  assign w_opportunistic = (sb_count >= HighWm) && !cache_port_busy;
  assign w_accept        = wr_valid && wr_ready;

  assign wr_info     = r_wr_info;
  assign drained_cnt = r_drained_cnt;

  always_comb begin
    w_state_d     = r_state;
    sb_get_oldest = 1'b0;
    wr_valid      = 1'b0;
    stall_pipe    = 1'b0;
    fence_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        stall_pipe = w_mandatory;
        // A search may invalidate the oldest entry, so never pop underneath it.
        if ((w_mandatory || w_opportunistic) && !sb_search_active && w_nonempty &&
            !cache_port_busy) begin
          sb_get_oldest = 1'b1;
          w_state_d     = StWrite;
        end
        fence_done = r_fence_pending && !w_nonempty && !sb_get_oldest;
      end
      StWrite: begin
        wr_valid = 1'b1;
        if (wr_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_fence_pending_d = (r_fence_pending && !fence_done) || fence_req;
    if (sb_push || sb_get_oldest || !w_nonempty) begin
      w_timer_d = '0;
    end else if ((r_state == StIdle) && (r_timer != TmrMax)) begin
      w_timer_d = r_timer + 1'b1;
    end else begin
      w_timer_d = r_timer;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= StIdle;
      r_timer         <= '0;
      r_fence_pending <= 1'b0;
      r_wr_info       <= '0;
      r_drained_cnt   <= '0;
    end else begin
      r_state         <= w_state_d;
      r_timer         <= w_timer_d;
      r_fence_pending <= w_fence_pending_d;
      if (sb_get_oldest) r_wr_info <= sb_oldest_info;
      if (w_accept) r_drained_cnt <= r_drained_cnt + 16'd1;
    end
  end

endmodule

// File: doc/store_buffer_drain_ctrl.md
Name: store_buffer_drain_ctrl

Overview:
- Controller that sequences draining of the data-cache store buffer into the data-cache write port.
- Decides when to pop the oldest store (watermark, full, fence, idle timeout) and latches it. Presents it to the cache with a valid/ready handshake.
- Arbitrates the shared cache port against pipeline lookups by stalling the pipe only when a drain is mandatory.
- Sits between the store buffer and the dcache tag/data write path.

Parameters:
- NUM_ENTRIES, 8: store buffer depth.
- CNT_W, 4: width of the occupancy count; holds 0..NUM_ENTRIES.
- HIGH_WM, 6: occupancy at or above which an opportunistic drain is requested.
- IDLE_TIMEOUT, 16: cycles of no push with a non-empty buffer before a forced drain.
- ENTRY_W, 128: packed width of one store buffer entry (addr, way, data, size, thread_id).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sb_count  in  CNT_W  number of valid store buffer entries (registered view).
- sb_push  in  1  a store is being pushed this cycle.
- sb_search_active  in  1  any thread search_valid is high this cycle.
- sb_oldest_info  in  ENTRY_W  oldest entry, combinational from the buffer.
- sb_get_oldest  out  1  pop the oldest entry this cycle.
- cache_port_busy  in  1  pipeline lookup owns the cache port this cycle.
- wr_valid  out  1  drain write request to the dcache.
- wr_info  out  ENTRY_W  latched store being written.
- wr_ready  in  1  dcache accepts the write.
- stall_pipe  out  1  blocks new pipeline lookups (mandatory drain pending).
- fence_req  in  1  level; request that the buffer be emptied.
- fence_done  out  1  one-cycle pulse when a fence completes.
- drained_cnt  out  16  count of accepted drain writes; wraps.

Behaviour:
- Reset state: all outputs are 0. The FSM is in IDLE, the idle timer is 0, and fence_pending is 0. A store latched mid-WRITE is discarded, because reset also clears the buffer.
- FSM states are IDLE and WRITE.
- mandatory = (sb_count == NUM_ENTRIES) | (fence_pending & sb_count != 0) | (timer == IDLE_TIMEOUT & sb_count != 0).
- opportunistic = (sb_count >= HIGH_WM) & !cache_port_busy.
- IDLE -> WRITE when (mandatory | opportunistic) & !sb_search_active & sb_count != 0 & !cache_port_busy. In that cycle:
  - sb_get_oldest = 1 for exactly one cycle;
  - wr_info <= sb_oldest_info.
- sb_search_active blocks the pop; the buffer may invalidate the same entry on a search hit. sb_get_oldest is never high while sb_search_active is high.
- stall_pipe = mandatory & (state == IDLE). This is combinational, so cache_port_busy deasserts on a following cycle. A mandatory pop still waits for !cache_port_busy.
- WRITE state:
  - wr_valid = 1 and wr_info is held stable until wr_ready.
  - When wr_valid & wr_ready: drained_cnt += 1 (mod 2^16) and next state is IDLE.
  - One bubble cycle is required between drains. No pop happens in WRITE.
- Idle timer:
  - Increments in IDLE when sb_count != 0 and sb_push == 0; saturates at IDLE_TIMEOUT.
  - Clears to 0 on sb_push, on a pop, or when sb_count == 0.
- Fence:
  - fence_req high sets fence_pending.
  - When fence_pending & sb_count == 0 & state == IDLE & !sb_get_oldest: fence_done pulses for 1 cycle and fence_pending clears.
  - A fence with an already empty buffer pulses fence_done the cycle after fence_req.
  - fence_req held high re-arms fence_pending on the next cycle; the requester drops it on fence_done.
- Simultaneous sb_push and pop is legal. sb_count is not adjusted locally; the buffer's registered count is authoritative.
- A full buffer while in WRITE: stall_pipe stays 0 until back in IDLE. The pipeline must not push when full; the buffer's buffer_full output handles that.

Test Plan:
- Reset, sb_count=0, idle 40 cycles -> no sb_get_oldest, wr_valid=0, stall_pipe=0, drained_cnt=0.
- sb_count=6, cache_port_busy=0, wr_ready=1 -> sb_get_oldest pulse at cycle t, wr_valid at t+1 with wr_info = sb_oldest_info sampled at t, drained_cnt=1 at t+2; next pop no earlier than t+2.
- sb_count=8, cache_port_busy=1 for 3 cycles -> stall_pipe=1 immediately, no pop until busy drops, then pop, stall_pipe=0 in WRITE.
- sb_count=2, no pushes, port free -> first pop 16 cycles after the last push; wr_ready low for 5 cycles -> wr_valid and wr_info held stable 5 cycles.
- fence_req with sb_count=3, count decrementing after each drain -> three drains back-to-back with bubbles, fence_done single pulse once count=0; fence_req with count=0 -> fence_done the next cycle.
- sb_search_active=1 with a trigger true -> sb_get_oldest stays 0 until search drops; reset asserted in WRITE -> wr_valid=0 and state IDLE the next cycle.
